// File: rtl/streaming_fifo_count_monitor_if.sv
// AXI4-Lite control bus for the FIFO count monitor. Signal names follow the
// s_axi_control_* channel names with the prefix carried by the instance name.
interface streaming_fifo_count_monitor_if;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/streaming_fifo_count_monitor.sv
// Occupancy monitor for a StreamingFIFO: samples count, tracks peak and the
// number of cycles at/above FULL_LEVEL, and exposes them over AXI4-Lite.
module streaming_fifo_count_monitor #(
  parameter int COUNT_WIDTH = 14,
  parameter int FULL_LEVEL  = 16383
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [COUNT_WIDTH-1:0] count,
  streaming_fifo_count_monitor_if.slave s_axi_control
);

  localparam logic [COUNT_WIDTH-1:0] FULL_THR = COUNT_WIDTH'(FULL_LEVEL);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wstate_next;
  rstate_t rstate, rstate_next;

  // Keeps the READY outputs low until the first edge after reset release.
  logic                   out_en;

  logic [COUNT_WIDTH-1:0] cur;
  logic [COUNT_WIDTH-1:0] peak;
  logic [31:0]            fullcyc;
  logic                   freeze;

  logic                   aw_got, w_got;
  logic [1:0]             aw_idx;
  logic [1:0]             wdata_q;
  logic                   wstrb0_q;
  logic [31:0]            rdata_q;

  logic                   aw_hs, w_hs, ar_hs;
  logic [1:0]             wr_idx;
  logic [1:0]             wr_data;
  logic                   wr_strb0;
  logic                   do_write, ctrl_wr, clear;
  logic [31:0]            rd_mux;

  // Address bits below the word index and unused data/strobe bits.
  logic unused_bits;
  assign unused_bits = ^{s_axi_control.AWADDR[1:0], s_axi_control.ARADDR[1:0],
                         s_axi_control.WDATA[31:2], s_axi_control.WSTRB[3:1]};

  // Handshake decode and write merge of captured vs. live AW/W beats.
  always_comb begin
    s_axi_control.AWREADY = out_en && (wstate == W_IDLE) && !aw_got;
    s_axi_control.WREADY  = out_en && (wstate == W_IDLE) && !w_got;
    s_axi_control.ARREADY = out_en && (rstate == R_IDLE);
    s_axi_control.BVALID  = (wstate == W_RESP);
    s_axi_control.RVALID  = (rstate == R_DATA);
    s_axi_control.BRESP   = 2'b00;
    s_axi_control.RRESP   = 2'b00;
    s_axi_control.RDATA   = rdata_q;
    aw_hs    = s_axi_control.AWVALID && s_axi_control.AWREADY;
    w_hs     = s_axi_control.WVALID  && s_axi_control.WREADY;
    ar_hs    = s_axi_control.ARVALID && s_axi_control.ARREADY;
    wr_idx   = aw_got ? aw_idx   : s_axi_control.AWADDR[3:2];
    wr_data  = w_got  ? wdata_q  : s_axi_control.WDATA[1:0];
    wr_strb0 = w_got  ? wstrb0_q : s_axi_control.WSTRB[0];
    do_write = (wstate == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    ctrl_wr  = do_write && (wr_idx == 2'd2) && wr_strb0;
    clear    = ctrl_wr && wr_data[0];
  end

  // Register read mux; sees values as they stand before the current edge.
  always_comb begin
    rd_mux = 32'd0;
    case (s_axi_control.ARADDR[3:2])
      2'd0: rd_mux = 32'(cur);
      2'd1: rd_mux = 32'(peak);
      2'd2: rd_mux = {30'd0, freeze, 1'b0};
      2'd3: rd_mux = fullcyc;
      default: rd_mux = 32'd0;
    endcase
  end

  // Write FSM next state.
  always_comb begin
    wstate_next = wstate;
    case (wstate)
      W_IDLE: if (do_write) wstate_next = W_RESP;
      W_RESP: if (s_axi_control.BREADY) wstate_next = W_IDLE;
      default: wstate_next = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    rstate_next = rstate;
    case (rstate)
      R_IDLE: if (ar_hs) rstate_next = R_DATA;
      R_DATA: if (s_axi_control.RREADY) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  // FSM state registers and the post-reset output enable.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
      out_en <= 1'b0;
    end else begin
      wstate <= wstate_next;
      rstate <= rstate_next;
      out_en <= 1'b1;
    end
  end

  // Capture AW and W beats independently until both halves are present.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_idx   <= 2'd0;
      wdata_q  <= 2'd0;
      wstrb0_q <= 1'b0;
    end else if (do_write) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_idx <= s_axi_control.AWADDR[3:2];
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        wdata_q  <= s_axi_control.WDATA[1:0];
        wstrb0_q <= s_axi_control.WSTRB[0];
      end
    end
  end

  // Read data latch, held until the R handshake frees the FSM.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rdata_q <= 32'd0;
    else if (ar_hs) rdata_q <= rd_mux;
  end

  // Occupancy statistics; a CLEAR write overrides both update and FREEZE.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cur     <= '0;
      peak    <= '0;
      fullcyc <= 32'd0;
      freeze  <= 1'b0;
    end else begin
      cur <= count;
      if (ctrl_wr) freeze <= wr_data[1];
      if (clear) begin
        peak    <= '0;
        fullcyc <= 32'd0;
      end else if (!freeze) begin
        if (cur > peak) peak <= cur;
        if ((cur >= FULL_THR) && (fullcyc != 32'hFFFF_FFFF)) fullcyc <= fullcyc + 32'd1;
      end
    end
  end

endmodule

// File: doc/streaming_fifo_count_monitor.md
# streaming_fifo_count_monitor

Observability block for StreamingFIFO instances: it samples a FIFO's `count` occupancy output and tracks peak occupancy and cycles spent at or above a full threshold. It exposes these values through an AXI4-Lite slave so the host control interface can read them, and can clear the peak and full-cycle statistics. One instance sits beside each monitored FIFO and is the reader side of the FIFO's `count` port.

## Interface
- `COUNT_WIDTH`, default 14: width of the monitored `count` input.
- `FULL_LEVEL`, default 16383: occupancy threshold for the full-cycle statistic; must fit in COUNT_WIDTH bits.
- `ap_clk`  in  1  single clock for all logic.
- `ap_rst_n`  in  1  reset, asynchronous and active-low.
- `count`  in  COUNT_WIDTH  occupancy from the monitored FIFO, synchronous to ap_clk.
- `s_axi_control_AWADDR`  in  4  write address; bits [3:2] select the register.
- `s_axi_control_AWVALID` in 1 / `s_axi_control_AWREADY` out 1: write-address handshake.
- `s_axi_control_WDATA`  in  32  write data.
- `s_axi_control_WSTRB`  in  4  byte strobes; only bit 0 is used.
- `s_axi_control_WVALID` in 1 / `s_axi_control_WREADY` out 1: write-data handshake.
- `s_axi_control_BRESP`  out  2  write response, always 2'b00 (OKAY).
- `s_axi_control_BVALID` out 1 / `s_axi_control_BREADY` in 1: write-response handshake.
- `s_axi_control_ARADDR`  in  4  read address; bits [3:2] select the register.
- `s_axi_control_ARVALID` in 1 / `s_axi_control_ARREADY` out 1: read-address handshake.
- `s_axi_control_RDATA`  out  32  read data.
- `s_axi_control_RRESP`  out  2  read response, always 2'b00 (OKAY).
- `s_axi_control_RVALID` out 1 / `s_axi_control_RREADY` in 1: read-data handshake.

## Operation
- **Register map (word index = ADDR[3:2]):**
  - 0 CUR (RO): count sampled at the previous edge, zero-extended to 32 bits.
  - 1 MAX (RO): peak of CUR since reset or the last clear.
  - 2 CTRL (RW): bit0 CLEAR (write 1, self-clearing, reads 0); bit1 FREEZE (when 1, MAX and FULLCYC hold); other bits read 0.
  - 3 FULLCYC (RO): number of cycles with CUR ≥ FULL_LEVEL; saturates at 0xFFFFFFFF.
- **Statistics update, every edge:**
  - CUR ← count.
  - If FREEZE=0: MAX ← max(MAX, CUR), and FULLCYC increments when CUR ≥ FULL_LEVEL and FULLCYC is not saturated.
  - A CLEAR write at the same edge forces MAX ← 0 and FULLCYC ← 0. Clear wins over update and over FREEZE.
- **Write FSM (W_IDLE → W_RESP):**
  - In W_IDLE, AWREADY=1 until an address is captured and WREADY=1 until data is captured. AW and W may arrive in either order or together.
  - At the edge where both have been captured, the write takes effect and the FSM moves to W_RESP with BVALID=1.
  - The CTRL write applies only if WSTRB[0]=1. Writes to other indices are ignored but still receive OKAY.
  - W_RESP holds BVALID until BVALID&BREADY, then returns to W_IDLE. AWREADY and WREADY are 0 in W_RESP.
- **Read FSM (R_IDLE → R_DATA):**
  - In R_IDLE, ARREADY=1. On ARVALID&ARREADY, RDATA latches the selected register's value as it stood before that edge's updates, and the FSM moves to R_DATA with RVALID=1.
  - RDATA and RVALID are held stable until RREADY. ARREADY=0 in R_DATA.
- The read and write FSMs are independent. A simultaneous read of MAX and CLEAR write returns the pre-clear MAX.
- **Reset (asynchronous assert):** all outputs 0, including the READYs, BVALID, RVALID, RDATA, BRESP and RRESP; CUR, MAX, FULLCYC and CTRL are 0; both FSMs go to IDLE. Asserting reset mid-transaction abandons it with no response. AWREADY, WREADY and ARREADY rise at the first edge after deassertion.

## Timing
- count → CUR: 1 cycle. count → MAX/FULLCYC: 2 cycles.
- Read latency: RVALID is high in the cycle after the AR handshake, i.e. 1 cycle. Back-to-back reads with RREADY tied high complete every 2 cycles.
- Write latency: BVALID is high in the cycle after the later of the AW and W handshakes. The CTRL effect is visible from that same edge.
- BVALID and RVALID never deassert without their ready; RDATA is stable while RVALID=1.

## Test plan
- **Reset:** hold ap_rst_n=0 with count=100 → all outputs 0. After release, CUR reads 100 and MAX reads 100 once 2 cycles have elapsed.
- **Peak and ordering:** drive count 5, 900, 12; read MAX → 900; read CUR → 12. Apply AW 2 cycles before W → BVALID one cycle after the W handshake, BRESP=0.
- **Clear vs. update:** with count=16383 (FULL_LEVEL) held for 10 cycles → FULLCYC=10. Write CTRL=1 while count=16383 → MAX=0 and FULLCYC=0 at that edge, then counting resumes. Same-cycle read of MAX returns 16383.
- **Freeze and strobe:** write CTRL=2, raise count to 16383 → MAX and FULLCYC unchanged; CTRL reads 2. Write CTRL=0 with WSTRB=0 → CTRL still reads 2.
- **Backpressure and unmapped write:** read with RREADY low for 5 cycles → RVALID and RDATA stable and ARREADY=0 throughout. Write to index 0 → OKAY, no state change.
- **Reset mid-read:** assert ap_rst_n during R_DATA → RVALID=0 immediately (asynchronous), ARREADY=1 at the first edge after release.
